cpu_cache_responder: RTL and testbench
======================================

// Module: cpu_cache_responder
// PURPOSE
// - Cache-side (follower) end of the CPU-cache request interface.
// - Accepts single-word load/store requests from the CPU leader and answers with a one-cycle ready pulse.
// - Direct-mapped, one 32-bit word per line. Write-through, no-write-allocate.
// - Misses and all stores go to main memory over a valid/ready memory port.
// - Sits between the CPU model (leader tasks) and the memory model.
// PARAMETERS
// - NUM_LINES  64  number of cache lines, power of 2; index = addr[2 +: $clog2(NUM_LINES)]
// - ADDR_W     32  request address width; tag = addr[ADDR_W-1 : 2+$clog2(NUM_LINES)]; addr[1:0] ignored
// - DATA_W     32  word width
// PORTS
// - clk          in   1       single clock, all state on posedge
// - rst          in   1       asynchronous, active-low reset
// - addr         in   ADDR_W  CPU request address
// - wr_data      in   DATA_W  CPU store data
// - rw           in   1       request type: 0 = read, 1 = write
// - valid        in   1       CPU request strobe; may stay high for several cycles
// - ready        out  1       one-cycle completion pulse
// - rd_data      out  DATA_W  load data; stable from the ready cycle until the next ready
// - mem_addr     out  ADDR_W  memory request address (word aligned, [1:0] = 0)
// - mem_wr_data  out  DATA_W  memory store data
// - mem_rw       out  1       0 = read, 1 = write
// - mem_valid    out  1       memory request; held until mem_ready is sampled high
// - mem_ready    in   1       memory completion, one cycle
// - mem_rd_data  in   DATA_W  memory read data, valid with mem_ready
// - hit_count    out  32      saturating count of read hits
// - miss_count   out  32      saturating count of read misses
// BEHAVIOUR
// - Reset (rst=0)
//   - All outputs 0. All line valid bits 0. Counters 0. State IDLE.
//   - Any in-flight memory transaction is abandoned: mem_valid drops immediately; no ready is issued.
// - Acceptance
//   - A request is accepted only on the rising edge of valid (valid=1 and valid_q=0 at posedge), only in IDLE.
//   - addr, rw and wr_data are captured at that edge.
//   - A rising edge in any other state is ignored; the protocol forbids it and the bench flags it.
// - States: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
//   - IDLE -> LOOKUP on acceptance.
//   - LOOKUP, read hit: rd_data <= line data; hit_count++; -> RESP.
//   - LOOKUP, read miss: miss_count++; -> MEM_RD.
//   - LOOKUP, write: on a hit, line data <= wr_data in the same cycle (no allocate on a miss); -> MEM_WR.
//   - MEM_RD: mem_valid=1, mem_rw=0, mem_addr={addr[ADDR_W-1:2],2'b00}.
//     - On mem_ready: fill line (valid=1, tag, data); rd_data <= mem_rd_data; -> RESP.
//   - MEM_WR: mem_valid=1, mem_rw=1, mem_wr_data=captured wr_data.
//     - On mem_ready: -> RESP.
//   - RESP: ready=1 for exactly one cycle; -> IDLE.
// - Latency
//   - Read hit: ready is high in the 2nd cycle after the accepting edge.
//   - Miss or store: ready is high in the cycle after the edge where mem_ready is sampled.
// - Memory port
//   - mem_* outputs are registered and change only on state entry.
//   - mem_valid falls the cycle after mem_ready; mem_ready outside MEM_RD/MEM_WR is ignored.
// - Store behaviour: rd_data is unchanged by stores; no read-modify-write.
// - Counters saturate at 32'hFFFF_FFFF.
// STRUCTURE
// - cache_pkg holds:
//   - state enum cache_state_e
//   - RW_READ/RW_WRITE constants
//   - line struct cache_line_t {valid, tag, data}
// - Sub-module cache_tag_store:
//   - NUM_LINES-entry line array, combinational read port by index, one synchronous write port
//   - async clear of all valid bits on rst
// - FSM, capture registers, edge detect and counters live in cpu_cache_responder.
// TESTING
// - After reset, read 0x0000_0040 with memory answering 0xDEADBEEF 3 cycles later
//   -> mem_valid with mem_addr 0x40, mem_rw 0; one ready pulse; rd_data 0xDEADBEEF; miss_count 1.
// - Read 0x40 again, valid held 2 cycles
//   -> no mem_valid; single ready in the 2nd cycle after acceptance; rd_data 0xDEADBEEF; hit_count 1.
// - Write 0x40 = 0x1234_5678
//   -> mem write of 0x1234_5678 to 0x40; ready after mem_ready; next read 0x40 hits with 0x1234_5678.
// - Read 0x140 (same index 16, different tag)
//   -> miss and line replaced; following read 0x40 misses again; miss_count increments both times.
// - Write 0x80 = 0xA5A5_A5A5 when 0x80 is not cached
//   -> mem write only, no allocation; following read 0x80 is a miss.
// - Assert rst while in MEM_RD
//   -> mem_valid and ready drop at once, counters cleared; after release, read 0x40 is a miss.

Source files
------------

// File: rtl/cpu_cache_responder_pkg.sv
// Shared types for the CPU-side cache responder: FSM states, request-type
// encodings and the per-line storage record.
package cache_pkg;

    localparam int CACHE_NUM_LINES = 64;
    localparam int CACHE_ADDR_W    = 32;
    localparam int CACHE_DATA_W    = 32;
    localparam int CACHE_IDX_W     = $clog2(CACHE_NUM_LINES);
    localparam int CACHE_TAG_W     = CACHE_ADDR_W - 2 - CACHE_IDX_W;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_RESP
    } cache_state_e;

    typedef struct packed {
        logic                   valid;
        logic [CACHE_TAG_W-1:0] tag;
        logic [CACHE_DATA_W-1:0] data;
    } cache_line_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cpu_cache_responder_if.sv
// CPU request bus (CPU is master) and memory port bus (cache is master).
interface cpu_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              rw;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] rd_data;

    modport master (output addr, wr_data, rw, valid, input ready, rd_data);
    modport slave  (input addr, wr_data, rw, valid, output ready, rd_data);
endinterface

interface mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              rw;
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] rd_data;

    modport master (output addr, wr_data, rw, valid, input ready, rd_data);
    modport slave  (input addr, wr_data, rw, valid, output ready, rd_data);
endinterface

// File: rtl/cpu_cache_responder_tag_store.sv
// Direct-mapped line store: combinational read by index, one synchronous
// write port. Only the valid bits are reset; tag/data stay RAM-friendly.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int NUM_LINES = CACHE_NUM_LINES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [$clog2(NUM_LINES)-1:0] rd_idx_i,
    output cache_line_t                  rd_line_o,
    input  logic                         we_i,
    input  logic [$clog2(NUM_LINES)-1:0] wr_idx_i,
    input  cache_line_t                  wr_line_i
);
    localparam int IDX_W = $clog2(NUM_LINES);

    logic [NUM_LINES-1:0]    valid_q;
    logic [CACHE_TAG_W-1:0]  tag_mem  [NUM_LINES];
    logic [CACHE_DATA_W-1:0] data_mem [NUM_LINES];

    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q[gi] <= 1'b0;
                end else if (we_i && (wr_idx_i == IDX_W'(gi))) begin
                    valid_q[gi] <= wr_line_i.valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_idx_i]  <= wr_line_i.tag;
            data_mem[wr_idx_i] <= wr_line_i.data;
        end
    end

    always_comb begin
        rd_line_o.valid = valid_q[rd_idx_i];
        rd_line_o.tag   = tag_mem[rd_idx_i];
        rd_line_o.data  = data_mem[rd_idx_i];
    end

endmodule

// File: rtl/cpu_cache_responder.sv
// Follower end of the CPU-cache request bus: direct-mapped, one word per line,
// write-through / no-write-allocate, misses and stores forwarded to memory.
module cpu_cache_responder
    import cache_pkg::*;
#(
    parameter int NUM_LINES = CACHE_NUM_LINES,
    parameter int ADDR_W    = CACHE_ADDR_W,
    parameter int DATA_W    = CACHE_DATA_W
) (
    input  logic        clk,
    input  logic        rst,
    cpu_req_if.slave    cpu,
    mem_port_if.master  mem,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    cache_state_e      state_q, state_d;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
    logic              mem_rw_q, mem_rw_d;
    logic              mem_valid_q, mem_valid_d;
    logic [31:0]       hit_q, hit_d;
    logic [31:0]       miss_q, miss_d;

    cache_line_t       rd_line, wr_line;
    logic              line_we;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [ADDR_W-1:0] req_word_addr;
    logic              lookup_hit;
    logic              accept;
    logic              unused_addr_bits;

    assign req_idx       = addr_q[2 +: IDX_W];
    assign req_tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign req_word_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign lookup_hit    = rd_line.valid && (rd_line.tag == req_tag);
    // Only a fresh rising edge of valid starts a request; a held strobe does not.
    assign accept        = cpu.valid && !valid_q && (state_q == ST_IDLE);
    assign unused_addr_bits = ^addr_q[1:0];

    cache_tag_store #(
        .NUM_LINES (NUM_LINES)
    ) u_tag_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (req_idx),
        .rd_line_o (rd_line),
        .we_i      (line_we),
        .wr_idx_i  (req_idx),
        .wr_line_i (wr_line)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            valid_q       <= 1'b0;
            addr_q        <= '0;
            rw_q          <= RW_READ;
            wr_data_q     <= '0;
            ready_q       <= 1'b0;
            rd_data_q     <= '0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_rw_q      <= 1'b0;
            mem_valid_q   <= 1'b0;
            hit_q         <= '0;
            miss_q        <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= cpu.valid;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            wr_data_q     <= wr_data_d;
            ready_q       <= ready_d;
            rd_data_q     <= rd_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_rw_q      <= mem_rw_d;
            mem_valid_q   <= mem_valid_d;
            hit_q         <= hit_d;
            miss_q        <= miss_d;
        end
    end

    // All registered outputs are set on entry to the state that owns them.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rw_d          = rw_q;
        wr_data_d     = wr_data_q;
        ready_d       = ready_q;
        rd_data_d     = rd_data_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_rw_d      = mem_rw_q;
        mem_valid_d   = mem_valid_q;
        hit_d         = hit_q;
        miss_d        = miss_q;
        line_we       = 1'b0;
        wr_line       = rd_line;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d    = cpu.addr;
                    rw_d      = cpu.rw;
                    wr_data_d = cpu.wr_data;
                    state_d   = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (rw_q == RW_READ) begin
                    if (lookup_hit) begin
                        rd_data_d = rd_line.data;
                        hit_d     = sat_inc(hit_q);
                        ready_d   = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        miss_d      = sat_inc(miss_q);
                        mem_valid_d = 1'b1;
                        mem_rw_d    = RW_READ;
                        mem_addr_d  = req_word_addr;
                        state_d     = ST_MEM_RD;
                    end
                end else begin
                    // Write-through: refresh a hit line, never allocate on a miss.
                    if (lookup_hit) begin
                        line_we      = 1'b1;
                        wr_line.data = wr_data_q;
                    end
                    mem_valid_d   = 1'b1;
                    mem_rw_d      = RW_WRITE;
                    mem_addr_d    = req_word_addr;
                    mem_wr_data_d = wr_data_q;
                    state_d       = ST_MEM_WR;
                end
            end
            ST_MEM_RD: begin
                if (mem.ready) begin
                    line_we       = 1'b1;
                    wr_line.valid = 1'b1;
                    wr_line.tag   = req_tag;
                    wr_line.data  = mem.rd_data;
                    rd_data_d     = mem.rd_data;
                    mem_valid_d   = 1'b0;
                    ready_d       = 1'b1;
                    state_d       = ST_RESP;
                end
            end
            ST_MEM_WR: begin
                if (mem.ready) begin
                    mem_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d     = 1'b0;
                mem_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign cpu.ready   = ready_q;
    assign cpu.rd_data = rd_data_q;
    assign mem.addr    = mem_addr_q;
    assign mem.wr_data = mem_wr_data_q;
    assign mem.rw      = mem_rw_q;
    assign mem.valid   = mem_valid_q;
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;

endmodule

// File: tb/tb_cpu_cache_responder.sv
// Randomised scoreboard bench for cpu_cache_responder with a behavioural
// cache/memory model and an interactive memory responder.
module tb_cpu_cache_responder;
    import cache_pkg::*;

    localparam int NL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    always #5 clk = ~clk;

    cpu_req_if  #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();
    mem_port_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    cpu_cache_responder #(
        .NUM_LINES (NL),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cpu_bus),
        .mem        (mem_bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] hits;
        logic [31:0] miss;
        bit          hit;
        bit          rw;
        logic [31:0] a;
        int          k;
    } resp_t;

    typedef struct {
        logic [31:0] a;
        bit          rw;
        logic [31:0] d;
    } memx_t;

    resp_t resp_q [$];
    memx_t memx_q [$];

    // Reference model: what the cache should hold, what memory should hold.
    bit          ref_valid [NL];
    logic [29:0] ref_word  [NL];
    logic [31:0] ref_data  [NL];
    logic [31:0] ref_mem   [logic [29:0]];
    logic [31:0] main_mem  [logic [29:0]];
    logic [31:0] exp_hits = '0;
    logic [31:0] exp_miss = '0;
    logic [31:0] exp_rd   = '0;

    function automatic logic [31:0] dflt(input logic [29:0] w);
        return {w[13:0], w[29:12]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    endfunction

    function automatic logic [31:0] main_rd(input logic [29:0] w);
        return main_mem.exists(w) ? main_mem[w] : dflt(w);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Memory responder
    int          mem_delay     = -1;
    int          mem_ready_cyc = -100;
    bit          mem_busy      = 1'b0;
    int          mem_cnt       = 0;
    logic [29:0] cur_w;
    bit          cur_rw;
    logic [31:0] cur_d;
    memx_t       mseen;

    initial begin
        mem_bus.ready   = 1'b0;
        mem_bus.rd_data = '0;
        forever begin
            @(negedge clk);
            mem_bus.ready = 1'b0;
            if (!rst) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy && mem_bus.valid) begin
                    if (memx_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_mem_req: actual addr %h rw %0d required no request",
                                 mem_bus.addr, mem_bus.rw);
                    end else begin
                        mseen = memx_q.pop_front();
                        check("mem_addr", mem_bus.addr, mseen.a);
                        check("mem_rw", 32'(mem_bus.rw), 32'(mseen.rw));
                        if (mseen.rw) check("mem_wr_data", mem_bus.wr_data, mseen.d);
                    end
                    cur_w    = mem_bus.addr[31:2];
                    cur_rw   = mem_bus.rw;
                    cur_d    = mem_bus.wr_data;
                    mem_busy = 1'b1;
                    mem_cnt  = (mem_delay >= 0) ? mem_delay : int'($urandom_range(0, 4));
                end
                if (mem_busy) begin
                    if (mem_cnt == 0) begin
                        mem_bus.ready = 1'b1;
                        if (cur_rw) begin
                            main_mem[cur_w] = cur_d;
                            mem_bus.rd_data = $urandom;
                        end else begin
                            mem_bus.rd_data = main_rd(cur_w);
                        end
                        mem_ready_cyc = cyc;
                        mem_busy      = 1'b0;
                    end else begin
                        mem_cnt--;
                    end
                end else if (!mem_bus.valid && ($urandom_range(0, 5) == 0)) begin
                    // Stray completion while idle must be ignored by the cache.
                    mem_bus.ready   = 1'b1;
                    mem_bus.rd_data = $urandom;
                end
            end
        end
    end

    // Monitor / scoreboard
    logic [31:0] last_rd = '0;
    resp_t       got;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                last_rd = '0;
            end else if (cpu_bus.ready) begin
                if (resp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: actual ready 1 at cycle %0d required 0", cyc);
                end else begin
                    got = resp_q.pop_front();
                    check("rd_data", cpu_bus.rd_data, got.rd);
                    check("hit_count", hit_count, got.hits);
                    check("miss_count", miss_count, got.miss);
                    check("ready_cycle", 32'(cyc), got.hit ? 32'(got.k + 2) : 32'(mem_ready_cyc + 1));
                    last_rd = got.rd;
                    $display("[TB] txn %s addr=%h %s rd_data=%h hits=%0d misses=%0d cycle=%0d",
                             got.rw ? "WR" : "RD", got.a, got.hit ? "hit " : "mem ",
                             cpu_bus.rd_data, hit_count, miss_count, cyc);
                end
            end else begin
                check("rd_data_stable", cpu_bus.rd_data, last_rd);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input bit rw, input logic [31:0] d);
        resp_t       e;
        memx_t       m;
        int          idx;
        logic [29:0] w;
        bit          hit;
        w   = a[31:2];
        idx = int'(a[7:2]);
        hit = ref_valid[idx] && (ref_word[idx] == w);
        m.a  = {w, 2'b00};
        m.rw = rw;
        m.d  = d;
        if (!rw) begin
            if (hit) begin
                exp_hits++;
                e.rd = ref_data[idx];
            end else begin
                exp_miss++;
                e.rd = ref_rd(w);
                ref_valid[idx] = 1'b1;
                ref_word[idx]  = w;
                ref_data[idx]  = e.rd;
                memx_q.push_back(m);
            end
            exp_rd = e.rd;
        end else begin
            if (hit) ref_data[idx] = d;
            ref_mem[w] = d;
            memx_q.push_back(m);
            e.rd = exp_rd;
        end
        e.hits = exp_hits;
        e.miss = exp_miss;
        e.hit  = !rw && hit;
        e.rw   = rw;
        e.a    = a;
        e.k    = cyc;
        resp_q.push_back(e);
        cpu_bus.addr    = a;
        cpu_bus.rw      = rw;
        cpu_bus.wr_data = d;
        cpu_bus.valid   = 1'b1;
    endtask

    task automatic complete(input int hold);
        repeat (hold) @(negedge clk);
        cpu_bus.valid   = 1'b0;
        cpu_bus.addr    = $urandom;
        cpu_bus.wr_data = $urandom;
        cpu_bus.rw      = 1'($urandom_range(0, 1));
        for (int i = 0; i < 100 && resp_q.size() != 0; i++) @(negedge clk);
        if (resp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: actual no ready within 100 cycles required one ready pulse");
            resp_q.delete();
            memx_q.delete();
        end
        check("mem_req_issued", 32'(memx_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] a, input bit rw, input logic [31:0] d, input int hold);
        @(negedge clk);
        issue(a, rw, d);
        complete(hold);
    endtask

    int n;

    initial begin
        cpu_bus.valid   = 1'b0;
        cpu_bus.addr    = '0;
        cpu_bus.rw      = 1'b0;
        cpu_bus.wr_data = '0;
        ref_mem[30'h10]  = 32'hDEAD_BEEF;
        main_mem[30'h10] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cpu_bus.ready), 32'd0);
        check("rst_rd_data", cpu_bus.rd_data, 32'd0);
        check("rst_mem_valid", 32'(mem_bus.valid), 32'd0);
        check("rst_mem_addr", mem_bus.addr, 32'd0);
        check("rst_mem_rw", 32'(mem_bus.rw), 32'd0);
        check("rst_mem_wr_data", mem_bus.wr_data, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        rst = 1'b1;

        mem_delay = 3;
        req(32'h0000_0040, 1'b0, 32'h0, 1);
        mem_delay = -1;
        req(32'h0000_0040, 1'b0, 32'h0, 2);
        req(32'h0000_0040, 1'b1, 32'h1234_5678, 1);
        req(32'h0000_0040, 1'b0, 32'h0, 1);
        req(32'h0000_0140, 1'b0, 32'h0, 1);
        req(32'h0000_0040, 1'b0, 32'h0, 1);
        req(32'h0000_0080, 1'b1, 32'hA5A5_A5A5, 1);
        req(32'h0000_0080, 1'b0, 32'h0, 1);

        // Reset while a read miss is waiting on memory.
        mem_delay = 30;
        @(negedge clk);
        issue(32'h0000_0200, 1'b0, 32'h0);
        @(negedge clk);
        cpu_bus.valid = 1'b0;
        n = 0;
        while (!mem_bus.valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mem_valid_before_reset", 32'(mem_bus.valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_mem_valid", 32'(mem_bus.valid), 32'd0);
        check("abort_ready", 32'(cpu_bus.ready), 32'd0);
        check("abort_hit_count", hit_count, 32'd0);
        check("abort_miss_count", miss_count, 32'd0);
        foreach (ref_valid[i]) ref_valid[i] = 1'b0;
        exp_hits = '0;
        exp_miss = '0;
        exp_rd   = '0;
        resp_q.delete();
        memx_q.delete();
        repeat (3) @(negedge clk);
        check("abort_rd_data", cpu_bus.rd_data, 32'd0);
        check("abort_mem_valid_held", 32'(mem_bus.valid), 32'd0);
        rst = 1'b1;
        mem_delay = -1;
        req(32'h0000_0040, 1'b0, 32'h0, 1);

        // Random traffic over a few tags aliasing onto a few lines.
        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = a | (32'($urandom_range(1, 255)) << 24);
            req(a, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
